compute_sequencer: RTL and testbench
====================================

# compute_sequencer

Sequences the six compute stages (EMB, MIX1, MIX2, MIX3, DENS, COMP) between the RECV and SEND phases of the top-level flow. On a start request it runs each enabled stage in order, holds a level `run` to that stage until its one-cycle `valid` returns, and flips the ping-pong intermediate-buffer select after each completed stage. It enforces a per-stage timeout, exposes busy/done/err status and a total cycle count for the AXI-Lite register block, and supports a mode-dependent stage skip.

## Interface
Parameters:
- `TIMEOUT`, 4096: max cycles a stage may hold `run` without `valid`; 0 disables the timeout.
- `CNT_W`, 32: width of `cycle_cnt`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: start request; accepted only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `mode` in 2: stage-set select, latched on accepted start.
- `stage_valid` in 6: completion strobes, bit i = stage i (0=EMB … 5=COMP).
- `stage_run` out 6: one-hot run level to the active stage.
- `stage_idx` out 3: active stage 0..5; 7 when not running.
- `buf_sel` out 1: ping-pong buffer select for the active stage.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on completion of the last stage.
- `err` out 1: high in ERR.
- `cycle_cnt` out CNT_W: cycles spent in RUN for the current/last job.

## Operation
- States: IDLE, RUN, ERR.
- Stage sets (latched `mode`): 0 = all six; 1 = EMB, MIX1, DENS, COMP (skip MIX2, MIX3); 2 = EMB, COMP; 3 = same as 0.
- IDLE: `start`=1 → RUN at first enabled stage (always EMB); `buf_sel`←0, `cycle_cnt`←0, stage timer←0.
- RUN: `stage_run` = one-hot of current stage. `stage_valid[cur]`=1 → advance to next enabled stage, toggle `buf_sel`, timer←0; if current is COMP → IDLE with `done` pulse.
- `stage_valid` bits for non-active stages ignored; multiple bits set: only `cur` bit considered.
- Timeout: timer counts cycles in current stage; when timer reaches TIMEOUT−1 with no `valid` → ERR. `valid` in that same cycle wins (normal advance).
- ERR: all `stage_run`=0; holds until `abort` → IDLE. `start` ignored.
- `abort` has priority over all other inputs in every state: next cycle IDLE, `stage_run`=0, `err`=0; no `done` pulse. `cycle_cnt` and `buf_sel` hold.
- `start` while in RUN or ERR ignored; `mode` changes outside accepted start ignored.
- `cycle_cnt` increments each cycle in RUN, saturates at 2^CNT_W−1, holds in IDLE/ERR until next accepted start.

## Timing
- Reset values: state IDLE, `stage_run`=0, `stage_idx`=7, `buf_sel`=0, `busy`=0, `done`=0, `err`=0, `cycle_cnt`=0, timer=0.
- All outputs registered.
- `start` sampled at edge t → `stage_run[0]`=1, `busy`=1, `stage_idx`=0 from cycle t+1.
- `stage_valid[cur]` sampled at edge u → next stage's `run` high from u+1 (zero bubble); old `run` low at u+1.
- Last-stage `valid` at u → `done`=1 for cycle u+1 only, `busy`=0, `stage_idx`=7 at u+1; new `start` accepted at u+1.
- Stage entered at cycle e, no `valid` → `err`=1, `stage_run`=0 from e+TIMEOUT.
- `cycle_cnt` after a full job = number of cycles `busy` was high.

## Test plan
- Mode 0, each stage returns `valid` 3 cycles after its `run` rises → runs in order 0..5, `buf_sel` 0,1,0,1,0,1, `done` one pulse, `cycle_cnt`=18.
- Mode 1 then mode 2, `valid` after 1 cycle → `stage_idx` sequences 0,1,4,5 and 0,5; `cycle_cnt`=4 and 2; `buf_sel` ends at 1 (mode 1) and 1 (mode 2).
- TIMEOUT=8, MIX1 never responds → `err`=1 exactly 8 cycles after `stage_run[1]` rises, `stage_run`=0; `start` ignored; `abort` → IDLE, `err`=0 next cycle.
- TIMEOUT=8, MIX1 `valid` on the 8th cycle → no error, MIX2 run next cycle.
- `abort` asserted with `stage_valid[cur]` during DENS → IDLE, no `done`, no advance; spurious `stage_valid[3]` during EMB → ignored.
- `rst` asserted mid-RUN (MIX2) → all outputs at reset values next cycle; `start` with `mode`=0 afterwards restarts at EMB with `cycle_cnt`=0.

Source files
------------

// File: rtl/compute_sequencer.sv
// Sequences the six compute stages (EMB, MIX1, MIX2, MIX3, DENS, COMP) with a
// per-stage timeout, ping-pong buffer select, status flags and a job cycle count.
module compute_sequencer #(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic [5:0]       stage_valid,
   output logic [5:0]       stage_run,
   output logic [2:0]       stage_idx,
   output logic             buf_sel,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   localparam int                TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [2:0]        IDX_NONE = 3'd7;
   localparam logic [2:0]        IDX_LAST = 3'd5;

   state_t           state;
   logic [1:0]       mode_q;
   logic [TMR_W-1:0] timer;
   logic             cur_valid;
   logic [2:0]       nxt_idx;

   // Next enabled stage after the current one for the latched stage set.
   function automatic logic [2:0] next_stage(input logic [2:0] cur, input logic [1:0] m);
      logic [2:0] nxt;
      nxt = cur + 3'd1;
      case (m)
         2'd1:    if (cur == 3'd1) nxt = 3'd4;
         2'd2:    nxt = IDX_LAST;
         default: nxt = cur + 3'd1;
      endcase
      return nxt;
   endfunction

   // stage_run is one-hot of the active stage, so masking with it keeps only
   // the current stage's strobe and discards the rest.
   assign cur_valid = |(stage_valid & stage_run);
   assign nxt_idx   = next_stage(stage_idx, mode_q);

   always_ff @(posedge clk) begin
      // NOTE: done is defaulted low every cycle so that any assignment below
      // yields exactly a one-cycle pulse; all state uses non-blocking updates.
      done <= 1'b0;
      if (rst) begin
         state     <= IDLE;
         mode_q    <= 2'd0;
         timer     <= '0;
         stage_run <= '0;
         stage_idx <= IDX_NONE;
         buf_sel   <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         cycle_cnt <= '0;
      end else if (abort) begin
         state     <= IDLE;
         timer     <= '0;
         stage_run <= '0;
         stage_idx <= IDX_NONE;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  mode_q    <= mode;
                  timer     <= '0;
                  stage_run <= 6'b000001;
                  stage_idx <= 3'd0;
                  buf_sel   <= 1'b0;
                  busy      <= 1'b1;
                  cycle_cnt <= '0;
               end
            end
            RUN: begin
               if (cycle_cnt != {CNT_W{1'b1}}) cycle_cnt <= cycle_cnt + CNT_W'(1);
               if (cur_valid) begin
                  timer <= '0;
                  if (stage_idx == IDX_LAST) begin
                     state     <= IDLE;
                     stage_run <= '0;
                     stage_idx <= IDX_NONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     stage_run <= 6'(1) << nxt_idx;
                     stage_idx <= nxt_idx;
                     buf_sel   <= ~buf_sel;
                  end
               end else if (TIMEOUT != 0) begin
                  if (timer == TMR_MAX) begin
                     state     <= ERR;
                     timer     <= '0;
                     stage_run <= '0;
                     stage_idx <= IDX_NONE;
                     busy      <= 1'b0;
                     err       <= 1'b1;
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end
            end
            ERR: begin
               err <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_compute_sequencer.sv
// Directed bench for compute_sequencer: stage ordering per mode, buffer select,
// cycle count, timeout, abort priority and synchronous reset.
module tb_compute_sequencer;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 32;

   logic             clk = 1'b0;
   logic             rst, start, abort;
   logic [1:0]       mode;
   logic [5:0]       stage_valid;
   logic [5:0]       stage_run;
   logic [2:0]       stage_idx;
   logic             buf_sel, busy, done, err;
   logic [CNT_W-1:0] cycle_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   compute_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .stage_valid(stage_valid), .stage_run(stage_run), .stage_idx(stage_idx),
      .buf_sel(buf_sel), .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " run"},  32'(stage_run), 32'd0);
      check({tag, " idx"},  32'(stage_idx), 32'd7);
      check({tag, " busy"}, 32'(busy),      32'd0);
      check({tag, " err"},  32'(err),       32'd0);
   endtask

   // Runs one full job; seq holds the expected stage indices, 3 bits each, first in LSBs.
   task automatic run_job(input string tag, input logic [1:0] m, input int lat,
                          input int n, input logic [17:0] seq);
      logic [2:0] s;
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode  = ~m;
      for (int i = 0; i < n; i++) begin
         s = seq[3*i +: 3];
         check({tag, " idx"},  32'(stage_idx), 32'(s));
         check({tag, " run"},  32'(stage_run), 32'(6'(1) << s));
         check({tag, " buf"},  32'(buf_sel),   32'(i % 2));
         check({tag, " busy"}, 32'(busy),      32'd1);
         for (int k = 0; k < lat; k++) begin
            if (k == lat - 1) stage_valid = 6'(1) << s;
            tick();
            stage_valid = '0;
         end
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check_idle({tag, " end"});
      check({tag, " cnt"},  cycle_cnt,   32'(n * lat));
      check({tag, " buf end"}, 32'(buf_sel), 32'((n - 1) % 2));
      tick();
      check({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; stage_valid = '0;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");
      check("reset buf",  32'(buf_sel),  32'd0);
      check("reset done", 32'(done),     32'd0);
      check("reset cnt",  cycle_cnt,     32'd0);

      run_job("mode0", 2'd0, 3, 6, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
      run_job("mode1", 2'd1, 1, 4, {3'd0, 3'd0, 3'd5, 3'd4, 3'd1, 3'd0});
      run_job("mode2", 2'd2, 1, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0});

      // Spurious strobe during EMB, then abort together with DENS valid.
      mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
      stage_valid = 6'b001000; tick(); stage_valid = '0;
      check("spurious idx", 32'(stage_idx), 32'd0);
      check("spurious run", 32'(stage_run), 32'd1);
      for (int s = 0; s < 4; s++) begin
         stage_valid = 6'(1) << s; tick(); stage_valid = '0;
      end
      check("dens idx", 32'(stage_idx), 32'd4);
      abort = 1'b1; stage_valid = 6'b010000; tick(); abort = 1'b0; stage_valid = '0;
      check_idle("abort");
      check("abort done", 32'(done),      32'd0);
      check("abort cnt",  cycle_cnt,      32'd5);
      check("abort buf",  32'(buf_sel),   32'd0);
      tick();
      check("abort no done", 32'(done), 32'd0);

      // MIX1 never responds: error exactly TIMEOUT cycles after its run rises.
      start = 1'b1; tick(); start = 1'b0;
      stage_valid = 6'b000001; tick(); stage_valid = '0;
      check("to mix1 run", 32'(stage_run), 32'd2);
      for (int k = 0; k < TIMEOUT - 1; k++) tick();
      check("to pre err", 32'(err),       32'd0);
      check("to pre run", 32'(stage_run), 32'd2);
      tick();
      check("to err",  32'(err),       32'd1);
      check("to run",  32'(stage_run), 32'd0);
      check("to busy", 32'(busy),      32'd0);
      check("to cnt",  cycle_cnt,      32'(1 + TIMEOUT));
      start = 1'b1; tick(); start = 1'b0;
      check("err start ignored", 32'(err),  32'd1);
      check("err start busy",    32'(busy), 32'd0);
      abort = 1'b1; tick(); abort = 1'b0;
      check_idle("err abort");

      // MIX1 valid on its last allowed cycle wins over the timeout.
      start = 1'b1; tick(); start = 1'b0;
      stage_valid = 6'b000001; tick(); stage_valid = '0;
      for (int k = 0; k < TIMEOUT - 1; k++) tick();
      stage_valid = 6'b000010; tick(); stage_valid = '0;
      check("late valid err", 32'(err),       32'd0);
      check("late valid run", 32'(stage_run), 32'd4);
      check("late valid idx", 32'(stage_idx), 32'd2);

      // Synchronous reset mid-MIX2, then a clean restart.
      rst = 1'b1; tick(); rst = 1'b0;
      check_idle("rst");
      check("rst cnt",  cycle_cnt,    32'd0);
      check("rst buf",  32'(buf_sel), 32'd0);
      check("rst done", 32'(done),    32'd0);
      mode = 2'd0; start = 1'b1; tick(); start = 1'b0;
      check("restart idx",  32'(stage_idx), 32'd0);
      check("restart run",  32'(stage_run), 32'd1);
      check("restart cnt",  cycle_cnt,      32'd0);
      check("restart busy", 32'(busy),      32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
